// File: rtl/alu_uart_intf.sv
// Sequencer between the UART receiver and transmitter: gathers A, B and opcode,
// latches the ALU result and starts one transmission. Optional macro: INTF_TIMEOUT_EN.
module alu_uart_intf #(
    parameter int N_BITS         = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [N_BITS-1:0]   i_rx_data,
    input  logic [N_BITS-1:0]   i_alu_result,
    input  logic                i_tx_done,
    output logic [N_BITS-1:0]   o_data_a,
    output logic [N_BITS-1:0]   o_data_b,
    output logic [OP_BITS-1:0]  o_op,
    output logic                o_tx_start,
    output logic [N_BITS-1:0]   o_tx_data,
    output logic                o_busy,
    output logic                o_timeout
);

    localparam logic [2:0] WAIT_A  = 3'd0;
    localparam logic [2:0] WAIT_B  = 3'd1;
    localparam logic [2:0] WAIT_OP = 3'd2;
    localparam logic [2:0] LATCH   = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] WAIT_TX = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [N_BITS-1:0]  data_a_q, data_a_d;
    logic [N_BITS-1:0]  data_b_q, data_b_d;
    logic [OP_BITS-1:0] op_q, op_d;
    logic [N_BITS-1:0]  tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               timeout_hit;
    logic               in_collect;

    assign in_collect = (state_q == WAIT_B) || (state_q == WAIT_OP);

`ifdef INTF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A tick arriving on the last allowed cycle takes priority over the timeout.
    assign timeout_hit = in_collect && !i_rx_done && (cnt_q == CNT_LAST);
    assign o_timeout   = timeout_hit;

    always_comb begin
        cnt_d = '0;
        if (in_collect && !i_rx_done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
    assign o_timeout          = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    data_a_d = i_rx_data;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    data_b_d = i_rx_data;
                    state_d  = WAIT_OP;
                end else if (timeout_hit) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[OP_BITS-1:0];
                    state_d = LATCH;
                end else if (timeout_hit) begin
                    state_d = WAIT_A;
                end
            end
            LATCH: begin
                // Start is registered here so it is high for exactly the SEND cycle.
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_op       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = (state_q != WAIT_A);

endmodule

// File: tb/tb_alu_uart_intf.sv
// Directed and randomized bench for alu_uart_intf with a triplet-level reference
// model and a small ALU model driving the result input.
module tb_alu_uart_intf;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    always #5 clk = ~clk;

    alu_uart_intf #(
        .N_BITS(8),
        .OP_BITS(6),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_rx_done(rx_done),
        .i_rx_data(rx_data),
        .i_alu_result(alu_result),
        .i_tx_done(tx_done),
        .o_data_a(data_a),
        .o_data_b(data_b),
        .o_op(op),
        .o_tx_start(tx_start),
        .o_tx_data(tx_data),
        .o_busy(busy),
        .o_timeout(timeout)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] code);
        case (code)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(data_a, data_b, op);

    always @(posedge clk) begin
        if (tx_start === 1'b1) starts <= starts + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        step();
        rx_done = 1'b0;
        rx_data = $urandom_range(0, 255);
    endtask

    // Runs one triplet up to the WAIT_TX state and checks every stage of it.
    task automatic do_triplet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
        int s0;
        logic [5:0] code;
        code = opb[5:0];
        s0 = starts;
        send_byte(a);
        check("capture_a", data_a, a);
        check("busy_after_a", busy, 1);
        send_byte(b);
        check("capture_b", data_b, b);
        send_byte(opb);
        check("capture_op", op, code);
        check("no_start_in_latch", tx_start, 0);
        step();
        check("tx_data", tx_data, alu_fn(a, b, code));
        check("start_in_send", tx_start, 1);
        step();
        check("start_one_cycle", tx_start, 0);
        check("busy_wait_tx", busy, 1);
        check("start_count_triplet", starts - s0, 1);
    endtask

    task automatic finish_tx();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("idle_after_tx_done", busy, 0);
    endtask

    logic [5:0] codes [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};

    initial begin
        int s0;
        int hit_cycle;
        int pulses;
        logic [7:0] ra, rb, ro;
        logic [1:0] hi;

        rst = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'hAA;
        tx_done = 1'b0;
        repeat (3) step();
        check("rst_data_a", data_a, 0);
        check("rst_data_b", data_b, 0);
        check("rst_op", op, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        rx_done = 1'b0;
        rst = 1'b0;
        step();
        check("idle_busy", busy, 0);
        check("no_start_after_rst", starts, 0);

        // Basic add
        do_triplet(8'h01, 8'h02, 8'h20);
        check("add_result", tx_data, 8'h03);
        check("add_op", op, 6'b100000);
        finish_tx();

        // Opcode masking
        do_triplet(8'h05, 8'h07, 8'hE0);
        check("mask_op", op, 6'b100000);
        check("mask_result", tx_data, 8'h0C);
        finish_tx();

        // Dropped bytes in WAIT_TX
        do_triplet(8'h40, 8'h11, 8'h22);
        s0 = starts;
        send_byte(8'h55);
        send_byte(8'h55);
        repeat (2) step();
        check("drop_no_restart", starts - s0, 0);
        check("drop_data_a", data_a, 8'h40);
        check("drop_busy", busy, 1);
        finish_tx();
        do_triplet(8'h10, 8'h20, 8'h20);
        check("after_drop_a", data_a, 8'h10);
        check("after_drop_res", tx_data, 8'h30);

        // tx_done and rx_done together in WAIT_TX
        tx_done = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h77;
        step();
        tx_done = 1'b0;
        rx_done = 1'b0;
        check("simul_idle", busy, 0);
        check("simul_data_a", data_a, 8'h10);
        step();
        check("simul_still_idle", busy, 0);

        // tx_done held high through a full triplet
        s0 = starts;
        tx_done = 1'b1;
        step();
        do_triplet(8'h09, 8'h03, 8'h22);
        repeat (4) step();
        check("held_done_one_start", starts - s0, 1);
        check("held_done_idle", busy, 0);
        tx_done = 1'b0;
        step();

        // Reset in the middle of a triplet
        s0 = starts;
        send_byte(8'hC3);
        send_byte(8'h3C);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_a", data_a, 0);
        check("midrst_b", data_b, 0);
        check("midrst_op", op, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_busy", busy, 0);
        repeat (3) step();
        check("midrst_no_start", starts - s0, 0);
        do_triplet(8'h03, 8'h04, 8'h20);
        check("midrst_fresh", tx_data, 8'h07);
        finish_tx();

        // Randomized triplets against the model, with noise in WAIT_TX
        for (int i = 0; i < 20; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            hi = $urandom_range(0, 3);
            ro = {hi, codes[$urandom_range(0, 5)]};
            do_triplet(ra, rb, ro);
            s0 = starts;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) send_byte($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) step();
            check("rand_no_extra_start", starts - s0, 0);
            check("rand_hold_a", data_a, ra);
            finish_tx();
            repeat ($urandom_range(0, 3)) step();
        end

        // Inter-byte timeout behaviour
        send_byte(8'h5A);
        hit_cycle = 0;
        pulses = 0;
        for (int i = 1; i <= 150; i++) begin
            if (timeout === 1'b1) begin
                pulses++;
                if (hit_cycle == 0) hit_cycle = i;
            end
            step();
        end
`ifdef INTF_TIMEOUT_EN
        check("timeout_pulses", pulses, 1);
        check("timeout_cycle", hit_cycle, 100);
        check("timeout_idle", busy, 0);
        check("timeout_keeps_a", data_a, 8'h5A);
`else
        check("no_timeout_pulses", pulses, 0);
        check("no_timeout_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_wait_rst_idle", busy, 0);
`endif
        do_triplet(8'h21, 8'h12, 8'h25);
        check("final_result", tx_data, 8'h33);
        finish_tx();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
